// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merge, exception flush sequencing, stall watchdog; PIPE_PERF_EN builds the perf counters.
module pipe_ctrl #(
  parameter int STALL_TIMEOUT = 1023,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);
  localparam logic [1:0] RUN = 2'd0, EXC = 2'd1, FLUSH = 2'd2;
  logic [1:0] state, state_nxt;
  logic [3:0] fcnt;
  logic [9:0] wd, wd_nxt;
  logic exc;
  assign exc = |excepttype_i;
  always_comb begin
    stall = (!rst || state != RUN) ? 6'b000000 :
            exc          ? 6'b111111 :
            stallreq_mem ? 6'b011111 :
            stallreq_ex  ? 6'b001111 :
            stallreq_id  ? 6'b000111 :
            stallreq_if  ? 6'b000011 : 6'b000000;
    state_nxt = state == RUN ? (exc ? EXC : RUN) :
                state == EXC ? (FLUSH_CYCLES == 1 ? RUN : FLUSH) :
                (fcnt <= 4'd2 ? RUN : FLUSH);
    // stall is already zero outside RUN, so stall[0] alone gates the watchdog
    wd_nxt = stall[0] ? (wd == 10'h3ff ? wd : wd + 10'd1) : 10'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      flush <= 1'b0;
      new_pc <= 32'h0;
      fcnt <= 4'd0;
      wd <= 10'd0;
      stall_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      flush <= state_nxt != RUN;
      if (state == RUN && exc) new_pc <= excepttype_i == 32'h0000000e ? cp0_epc_i : 32'h00000020;
      fcnt <= state == EXC ? 4'(FLUSH_CYCLES) : state == FLUSH ? fcnt - 4'd1 : fcnt;
      wd <= wd_nxt;
      stall_timeout <= stall_timeout | (wd_nxt == 10'(STALL_TIMEOUT));
    end
  end
`ifdef PIPE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= 32'h0;
      flush_count <= 16'h0;
    end else begin
      if (stall[0] && stall_cycles != 32'hffffffff) stall_cycles <= stall_cycles + 32'd1;
      if (state == RUN && exc) flush_count <= flush_count + 16'd1;
    end
  end
`else
  assign stall_cycles = 32'h0;
  assign flush_count = 16'h0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of stall merge, exception flush, watchdog, reset abort and perf counters.
module tb_pipe_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic rif = 1'b0, rid = 1'b0, rex = 1'b0, rmem = 1'b0;
  logic [31:0] exc = 32'h0, epc = 32'h0;
  logic [5:0] stall;
  logic flush, to;
  logic [31:0] new_pc, sc;
  logic [15:0] fc;
  int n_checks = 0, n_fail = 0;

  pipe_ctrl #(.STALL_TIMEOUT(8), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .stallreq_if(rif), .stallreq_id(rid), .stallreq_ex(rex),
    .stallreq_mem(rmem), .excepttype_i(exc), .cp0_epc_i(epc), .stall(stall), .flush(flush),
    .new_pc(new_pc), .stall_timeout(to), .stall_cycles(sc), .flush_count(fc)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rmem = 1'b1;
    cyc(); #1;
    n_checks++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL reset_stall got %b exp 000000", stall); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b exp 0", flush); end
    n_checks++; if (new_pc !== 32'h0) begin n_fail++; $display("FAIL reset_new_pc got %h exp 0", new_pc); end
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b exp 0", to); end
    n_checks++; if (sc !== 32'h0) begin n_fail++; $display("FAIL reset_stall_cycles got %h exp 0", sc); end
    n_checks++; if (fc !== 16'h0) begin n_fail++; $display("FAIL reset_flush_count got %h exp 0", fc); end
  endtask

  task automatic test_priority();
    cyc(); rst = 1'b1; rif = 1'b1; rid = 1'b1; rex = 1'b1; rmem = 1'b1; #1;
    n_checks++; if (stall !== 6'b011111) begin n_fail++; $display("FAIL prio_mem got %b exp 011111", stall); end
    cyc(); rmem = 1'b0; #1;
    n_checks++; if (stall !== 6'b001111) begin n_fail++; $display("FAIL prio_ex got %b exp 001111", stall); end
    cyc(); rex = 1'b0; #1;
    n_checks++; if (stall !== 6'b000111) begin n_fail++; $display("FAIL prio_id got %b exp 000111", stall); end
    cyc(); rid = 1'b0; #1;
    n_checks++; if (stall !== 6'b000011) begin n_fail++; $display("FAIL prio_if got %b exp 000011", stall); end
    cyc(); rif = 1'b0; #1;
    n_checks++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL prio_none got %b exp 000000", stall); end
  endtask

  task automatic test_exc_stall();
    cyc(); rmem = 1'b1; exc = 32'h8; #1;
    n_checks++; if (stall !== 6'b111111) begin n_fail++; $display("FAIL exc_freeze got %b exp 111111", stall); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL exc_flush_n got %b exp 0", flush); end
    for (int i = 0; i < 3; i++) begin
      cyc(); exc = 32'h0; #1;
      n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL exc_flush[%0d] got %b exp 1", i, flush); end
      n_checks++; if (new_pc !== 32'h20) begin n_fail++; $display("FAIL exc_new_pc[%0d] got %h exp 00000020", i, new_pc); end
      n_checks++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL exc_stall[%0d] got %b exp 000000", i, stall); end
    end
    cyc(); #1;
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL exc_resume_flush got %b exp 0", flush); end
    n_checks++; if (stall !== 6'b011111) begin n_fail++; $display("FAIL exc_resume_stall got %b exp 011111", stall); end
  endtask

  task automatic test_eret();
    cyc(); rmem = 1'b0; exc = 32'he; epc = 32'h00400104; #1;
    n_checks++; if (stall !== 6'b111111) begin n_fail++; $display("FAIL eret_freeze got %b exp 111111", stall); end
    for (int i = 0; i < 2; i++) begin
      cyc(); exc = 32'h8; #1;
      n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL eret_flush[%0d] got %b exp 1", i, flush); end
      n_checks++; if (new_pc !== 32'h00400104) begin n_fail++; $display("FAIL eret_new_pc[%0d] got %h exp 00400104", i, new_pc); end
      n_checks++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL eret_stall[%0d] got %b exp 000000", i, stall); end
    end
    cyc(); exc = 32'h0; #1;
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL eret_flush_last got %b exp 1", flush); end
    cyc(); #1;
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL eret_end_flush got %b exp 0", flush); end
    n_checks++; if (new_pc !== 32'h00400104) begin n_fail++; $display("FAIL eret_hold_new_pc got %h exp 00400104", new_pc); end
    n_checks++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL eret_end_stall got %b exp 000000", stall); end
  endtask

  task automatic test_watchdog();
    for (int i = 0; i < 7; i++) begin cyc(); rex = 1'b1; #1; end
    cyc(); rex = 1'b0; #1;
    for (int i = 0; i < 7; i++) begin cyc(); rex = 1'b1; #1; end
    cyc(); rex = 1'b0; #1;
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL wd_split got %b exp 0", to); end
    for (int i = 0; i < 8; i++) begin cyc(); rex = 1'b1; #1; end
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL wd_early got %b exp 0", to); end
    cyc(); rex = 1'b0; #1;
    n_checks++; if (to !== 1'b1) begin n_fail++; $display("FAIL wd_rise got %b exp 1", to); end
    cyc(); #1;
    n_checks++; if (to !== 1'b1) begin n_fail++; $display("FAIL wd_sticky got %b exp 1", to); end
  endtask

  task automatic test_reset_mid_flush();
    cyc(); exc = 32'h8; #1;
    cyc(); exc = 32'h0; #1;
    cyc(); rst = 1'b0; rmem = 1'b1; #1;
    n_checks++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL rmf_stall_in_reset got %b exp 000000", stall); end
    cyc(); rst = 1'b1; #1;
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rmf_flush got %b exp 0", flush); end
    n_checks++; if (new_pc !== 32'h0) begin n_fail++; $display("FAIL rmf_new_pc got %h exp 0", new_pc); end
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rmf_timeout got %b exp 0", to); end
    n_checks++; if (stall !== 6'b011111) begin n_fail++; $display("FAIL rmf_run_stall got %b exp 011111", stall); end
  endtask

  task automatic test_perf();
    logic [31:0] exp_sc5, exp_sc7;
    logic [15:0] exp_fc;
`ifdef PIPE_PERF_EN
    exp_sc5 = 32'd5; exp_sc7 = 32'd7; exp_fc = 16'd2;
`else
    exp_sc5 = 32'd0; exp_sc7 = 32'd0; exp_fc = 16'd0;
`endif
    cyc(); rst = 1'b0; rmem = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin cyc(); rst = 1'b1; rif = 1'b1; #1; end
    cyc(); rif = 1'b0; #1;
    n_checks++; if (sc !== exp_sc5) begin n_fail++; $display("FAIL perf_stall5 got %0d exp %0d", sc, exp_sc5); end
    for (int k = 0; k < 2; k++) begin
      cyc(); exc = 32'h8; #1;
      cyc(); exc = 32'h0; #1;
      cyc(); #1;
      cyc(); #1;
    end
    cyc(); #1;
    n_checks++; if (sc !== exp_sc7) begin n_fail++; $display("FAIL perf_stall7 got %0d exp %0d", sc, exp_sc7); end
    n_checks++; if (fc !== exp_fc) begin n_fail++; $display("FAIL perf_flush_count got %0d exp %0d", fc, exp_fc); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL perf_idle_flush got %b exp 0", flush); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_exc_stall();
    test_eret();
    test_watchdog();
    test_reset_mid_flush();
    test_perf();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
